multicycle_ctrl: RTL

//  Multi-cycle CPU control unit; the issuing end of the datapath ALU interface.

---
 rtl/mccu_pkg.sv | 69 ++++++
 rtl/multicycle_ctrl_if.sv | 48 ++++
 rtl/multicycle_ctrl_alu_op_decode.sv | 29 ++
 rtl/multicycle_ctrl.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/mccu_pkg.sv
// Purpose : shared types and constants for the multi-cycle control unit.
// Latency : n/a (declarations only).
// Backpr. : n/a.
// Contents: state enum, OP/func codes, ALU_OP encodings, ALU_SrcB / PC_s select codes,
//           and a helper that flags the R-type functions that can raise an overflow trap.
package mccu_pkg;

  localparam int ST_W = 4;

  typedef enum logic [ST_W-1:0] {
    S_IF   = 4'd0,
    S_ID   = 4'd1,
    S_EX_R = 4'd2,
    S_WB_R = 4'd3,
    S_EX_I = 4'd4,
    S_WB_I = 4'd5,
    S_MA   = 4'd6,
    S_MRD  = 4'd7,
    S_WB_L = 4'd8,
    S_MWR  = 4'd9,
    S_BEQ  = 4'd10,
    S_J    = 4'd11
  } state_t;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  // R-type function codes (IR[5:0])
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_SLLV = 6'b000100;

  // ALU operation encodings
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_XOR = 3'b010;
  localparam logic [2:0] ALU_NOR = 3'b011;
  localparam logic [2:0] ALU_ADD = 3'b100;
  localparam logic [2:0] ALU_SUB = 3'b101;
  localparam logic [2:0] ALU_SLT = 3'b110;
  localparam logic [2:0] ALU_SLL = 3'b111;

  // ALU operand B selects
  localparam logic [1:0] SRCB_RT     = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  // PC source selects
  localparam logic [1:0] PCS_ALU  = 2'b00;
  localparam logic [1:0] PCS_BR   = 2'b01;
  localparam logic [1:0] PCS_JUMP = 2'b10;

  // Only signed add/sub can trap on overflow; SLT and the logic ops never do.
  function automatic logic is_ovf_func(input logic [5:0] fn);
    return (fn == FN_ADD) || (fn == FN_SUB);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Purpose : bundle between the control unit (master) and the datapath (slave).
// Latency : n/a (wires only).
// Backpr. : mem_ready is the only stall input; the controller holds IF/MRD/MWR until it is high.
// Signals : IR fields OP/func, ALU flags ZF/OF, mem_ready in; ALU/PC/IR/memory/regfile controls out.
//           ovf_trap exists only when OVERFLOW_TRAP_EN is defined.
interface multicycle_ctrl_if;
  logic [5:0] OP;
  logic [5:0] func;
  logic       ZF;
  logic       OF;
  logic       mem_ready;
  logic [2:0] ALU_OP;
  logic       ALU_SrcA;
  logic [1:0] ALU_SrcB;
  logic       PC_Write;
  logic [1:0] PC_s;
  logic       IR_Write;
  logic       Mem_Write;
  logic       Reg_Write;
  logic       RegDst;
  logic       MemtoReg;
  logic       ill_instr;
`ifdef OVERFLOW_TRAP_EN
  logic       ovf_trap;

  modport master (
    input  OP, func, ZF, OF, mem_ready,
    output ALU_OP, ALU_SrcA, ALU_SrcB, PC_Write, PC_s, IR_Write,
           Mem_Write, Reg_Write, RegDst, MemtoReg, ill_instr, ovf_trap
  );
  modport slave (
    output OP, func, ZF, OF, mem_ready,
    input  ALU_OP, ALU_SrcA, ALU_SrcB, PC_Write, PC_s, IR_Write,
           Mem_Write, Reg_Write, RegDst, MemtoReg, ill_instr, ovf_trap
  );
`else
  modport master (
    input  OP, func, ZF, OF, mem_ready,
    output ALU_OP, ALU_SrcA, ALU_SrcB, PC_Write, PC_s, IR_Write,
           Mem_Write, Reg_Write, RegDst, MemtoReg, ill_instr
  );
  modport slave (
    output OP, func, ZF, OF, mem_ready,
    input  ALU_OP, ALU_SrcA, ALU_SrcB, PC_Write, PC_s, IR_Write,
           Mem_Write, Reg_Write, RegDst, MemtoReg, ill_instr
  );
`endif
endinterface

// File: rtl/multicycle_ctrl_alu_op_decode.sv
// Purpose : R-type func field -> ALU operation, plus a legal flag for unsupported funcs.
// Latency : combinational.
// Backpr. : none.
// Ports   : i_func (6) in; o_alu_op (3), o_legal (1) out.
module alu_op_decode
  import mccu_pkg::*;
(
  input  logic [5:0] i_func,
  output logic [2:0] o_alu_op,
  output logic       o_legal
);

  always_comb begin
    o_alu_op = ALU_ADD;
    o_legal  = 1'b1;
    case (i_func)
      FN_AND:  o_alu_op = ALU_AND;
      FN_OR:   o_alu_op = ALU_OR;
      FN_XOR:  o_alu_op = ALU_XOR;
      FN_NOR:  o_alu_op = ALU_NOR;
      FN_ADD:  o_alu_op = ALU_ADD;
      FN_SUB:  o_alu_op = ALU_SUB;
      FN_SLT:  o_alu_op = ALU_SLT;
      FN_SLLV: o_alu_op = ALU_SLL;
      default: o_legal  = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Purpose : multi-cycle MIPS-subset control FSM (IF/ID/EX/MEM/WB) driving the datapath.
// Latency : R/addi/sw 4 cycles, beq/j 3, lw 5; +1 cycle per mem_ready=0 cycle in IF/MRD/MWR.
// Backpr. : IF, MRD and MWR hold until mem_ready; all other states advance every cycle.
// Ports   : clk, rst (sync, active-high); io_ctrl = multicycle_ctrl_if.master.
// Config  : OVERFLOW_TRAP_EN - latch OF in EX (add/sub/addi), suppress the write-back and
//           pulse ovf_trap when set. Undefined: OF ignored, no ovf_trap signal.
module multicycle_ctrl
  import mccu_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  multicycle_ctrl_if.master      io_ctrl
);

  state_t     r_state;
  state_t     w_next;
  logic [2:0] w_dec_op;
  logic       w_dec_legal;

  logic [2:0] w_alu_op;
  logic       w_src_a;
  logic [1:0] w_src_b;
  logic       w_pc_write;
  logic [1:0] w_pc_s;
  logic       w_ir_write;
  logic       w_mem_write;
  logic       w_reg_write;
  logic       w_reg_dst;
  logic       w_mem_to_reg;
  logic       w_ill;
  logic       w_wb_ok;   // write-back permitted (cleared by a latched overflow trap)
  logic       w_trap;

  alu_op_decode u_dec (
    .i_func   (io_ctrl.func),
    .o_alu_op (w_dec_op),
    .o_legal  (w_dec_legal)
  );

`ifdef OVERFLOW_TRAP_EN
  logic r_ovf;

  // OF is only meaningful in the cycle the ALU computes the result, so capture it there
  // and act on it in the following write-back state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (r_state == S_EX_R) begin
      r_ovf <= io_ctrl.OF & w_dec_legal & is_ovf_func(io_ctrl.func);
    end else if (r_state == S_EX_I) begin
      r_ovf <= io_ctrl.OF;
    end
  end

  assign w_wb_ok = ~r_ovf;
  assign io_ctrl.ovf_trap = w_trap;
`else
  assign w_wb_ok = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IF;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next       = r_state;
    w_alu_op     = ALU_ADD;
    w_src_a      = 1'b0;
    w_src_b      = SRCB_RT;
    w_pc_write   = 1'b0;
    w_pc_s       = PCS_ALU;
    w_ir_write   = 1'b0;
    w_mem_write  = 1'b0;
    w_reg_write  = 1'b0;
    w_reg_dst    = 1'b0;
    w_mem_to_reg = 1'b0;
    w_ill        = 1'b0;
    w_trap       = 1'b0;

    case (r_state)
      S_IF: begin
        w_src_b = SRCB_FOUR;
        if (io_ctrl.mem_ready) begin
          w_ir_write = 1'b1;
          w_pc_write = 1'b1;
          w_next     = S_ID;
        end
      end
      S_ID: begin
        // Branch target is computed speculatively here and parked in ALUOut.
        w_src_b = SRCB_IMM_SH;
        case (io_ctrl.OP)
          OP_RTYPE:      w_next = S_EX_R;
          OP_ADDI:       w_next = S_EX_I;
          OP_LW, OP_SW:  w_next = S_MA;
          OP_BEQ:        w_next = S_BEQ;
          OP_J:          w_next = S_J;
          default: begin
            w_ill  = 1'b1;
            w_next = S_IF;
          end
        endcase
      end
      S_EX_R: begin
        w_src_a = 1'b1;
        if (w_dec_legal) begin
          w_alu_op = w_dec_op;
          w_next   = S_WB_R;
        end else begin
          w_ill  = 1'b1;
          w_next = S_IF;
        end
      end
      S_WB_R: begin
        w_reg_write = w_wb_ok;
        w_trap      = ~w_wb_ok;
        w_reg_dst   = 1'b1;
        w_next      = S_IF;
      end
      S_EX_I: begin
        w_src_a = 1'b1;
        w_src_b = SRCB_IMM;
        w_next  = S_WB_I;
      end
      S_WB_I: begin
        w_reg_write = w_wb_ok;
        w_trap      = ~w_wb_ok;
        w_next      = S_IF;
      end
      S_MA: begin
        w_src_a = 1'b1;
        w_src_b = SRCB_IMM;
        w_next  = (io_ctrl.OP == OP_SW) ? S_MWR : S_MRD;
      end
      S_MRD: begin
        if (io_ctrl.mem_ready) w_next = S_WB_L;
      end
      S_WB_L: begin
        w_reg_write  = 1'b1;
        w_mem_to_reg = 1'b1;
        w_next       = S_IF;
      end
      S_MWR: begin
        // Strobe stays up through the acknowledging cycle.
        w_mem_write = 1'b1;
        if (io_ctrl.mem_ready) w_next = S_IF;
      end
      S_BEQ: begin
        w_src_a    = 1'b1;
        w_alu_op   = ALU_SUB;
        w_pc_s     = PCS_BR;
        w_pc_write = io_ctrl.ZF;
        w_next     = S_IF;
      end
      S_J: begin
        w_pc_s     = PCS_JUMP;
        w_pc_write = 1'b1;
        w_next     = S_IF;
      end
      default: w_next = S_IF;
    endcase

    // Reset masks every strobe in the same cycle so an interrupted instruction
    // leaves no partial write behind.
    if (rst) begin
      w_alu_op     = ALU_ADD;
      w_src_a      = 1'b0;
      w_src_b      = SRCB_RT;
      w_pc_write   = 1'b0;
      w_pc_s       = PCS_ALU;
      w_ir_write   = 1'b0;
      w_mem_write  = 1'b0;
      w_reg_write  = 1'b0;
      w_reg_dst    = 1'b0;
      w_mem_to_reg = 1'b0;
      w_ill        = 1'b0;
      w_trap       = 1'b0;
    end
  end

  assign io_ctrl.ALU_OP    = w_alu_op;
  assign io_ctrl.ALU_SrcA  = w_src_a;
  assign io_ctrl.ALU_SrcB  = w_src_b;
  assign io_ctrl.PC_Write  = w_pc_write;
  assign io_ctrl.PC_s      = w_pc_s;
  assign io_ctrl.IR_Write  = w_ir_write;
  assign io_ctrl.Mem_Write = w_mem_write;
  assign io_ctrl.Reg_Write = w_reg_write;
  assign io_ctrl.RegDst    = w_reg_dst;
  assign io_ctrl.MemtoReg  = w_mem_to_reg;
  assign io_ctrl.ill_instr = w_ill;

endmodule
